// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bus between the IF/ID sequencing logic and the pipeline
// registers: hazard inputs from ID/EX plus the hold/flush/bubble controls.
interface pipeline_hazard_controller_if;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        IFID_UsesRt;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic        BranchTaken;
  logic        DMemBusy;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        FlushSignal;
  logic        PipeFreeze;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt, BranchTaken, DMemBusy,
    input  PCWrite, IFIDWrite, IDEXBubble, FlushSignal, PipeFreeze, StallCount, FlushCount
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt, BranchTaken, DMemBusy,
    output PCWrite, IFIDWrite, IDEXBubble, FlushSignal, PipeFreeze, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Front-end hazard sequencer: memory freeze > branch flush > load-use stall.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                       Clk,
  input logic                       Rst,
  pipeline_hazard_controller_if.slave Hz
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : gBadFlushCycles
    $error("FLUSH_CYCLES must be in 1..3");
  end

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t     state, stateNext;
  logic       pending, pendingNext;
  logic [1:0] fcnt, fcntNext;
  logic       loadUse, effBranch, flushEvent;
  logic       pcWrite, ifidWrite, idexBubble, flushSig, pipeFreeze;

  assign loadUse = Hz.IDEX_MemRead && (Hz.IDEX_Rt != '0) &&
                   ((Hz.IDEX_Rt == Hz.IFID_Rs) ||
                    (Hz.IFID_UsesRt && (Hz.IDEX_Rt == Hz.IFID_Rt)));

  // pending is only ever set while in MEM_WAIT, so RUN and MEM_WAIT share one path.
  assign effBranch = Hz.BranchTaken | pending;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= RUN;
      pending <= 1'b0;
      fcnt    <= '0;
    end else begin
      state   <= stateNext;
      pending <= pendingNext;
      fcnt    <= fcntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    pendingNext = pending;
    fcntNext    = fcnt;
    pcWrite     = 1'b0;
    ifidWrite   = 1'b0;
    idexBubble  = 1'b0;
    flushSig    = 1'b0;
    pipeFreeze  = 1'b0;
    flushEvent  = 1'b0;
    unique case (state)
      RUN, MEM_WAIT: begin
        if (Hz.DMemBusy) begin
          pcWrite     = 1'b1;
          ifidWrite   = 1'b1;
          pipeFreeze  = 1'b1;
          pendingNext = effBranch;
          stateNext   = MEM_WAIT;
        end else begin
          pendingNext = 1'b0;
          stateNext   = RUN;
          if (effBranch) begin
            flushSig   = 1'b1;
            idexBubble = 1'b1;
            flushEvent = 1'b1;
            fcntNext   = 2'(FLUSH_CYCLES - 1);
            if (FLUSH_CYCLES > 1) stateNext = FLUSH;
          end else if (loadUse) begin
            pcWrite    = 1'b1;
            ifidWrite  = 1'b1;
            idexBubble = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (Hz.DMemBusy) begin
          pcWrite    = 1'b1;
          ifidWrite  = 1'b1;
          pipeFreeze = 1'b1;
        end else begin
          flushSig   = 1'b1;
          idexBubble = 1'b1;
          if (fcnt == 2'd1) stateNext = RUN;
          else              fcntNext  = fcnt - 2'd1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  // Mealy outputs would otherwise follow live inputs during reset.
  assign Hz.PCWrite     = pcWrite    & ~Rst;
  assign Hz.IFIDWrite   = ifidWrite  & ~Rst;
  assign Hz.IDEXBubble  = idexBubble & ~Rst;
  assign Hz.FlushSignal = flushSig   & ~Rst;
  assign Hz.PipeFreeze  = pipeFreeze & ~Rst;

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCnt, flushCnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (ifidWrite && (stallCnt != '1)) stallCnt <= stallCnt + 16'd1;
      if (flushEvent && (flushCnt != '1)) flushCnt <= flushCnt + 16'd1;
    end
  end

  assign Hz.StallCount = stallCnt;
  assign Hz.FlushCount = flushCnt;
`else
  assign Hz.StallCount = '0;
  assign Hz.FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller (FLUSH_CYCLES=2 and =3 instances).
module tb_pipeline_hazard_controller;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // {PCWrite, IFIDWrite, IDEXBubble, FlushSignal, PipeFreeze}
  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] FRZ  = 5'b11001;
  localparam logic [4:0] FL   = 5'b00110;
  localparam logic [4:0] LUS  = 5'b11100;

  typedef struct {
    logic [4:0] rs, rt, idexRt;
    logic       uses, memRd, br, busy;
    logic [4:0] exp;
  } stim_t;

  logic Clk, Rst;
  int   nChecks = 0;
  int   nFail   = 0;
  logic [4:0] sbq[$];
  logic [4:0] exp;

  pipeline_hazard_controller_if if2 ();
  pipeline_hazard_controller_if if3 ();

  pipeline_hazard_controller #(.FLUSH_CYCLES(2)) dut2 (.Clk(Clk), .Rst(Rst), .Hz(if2.slave));
  pipeline_hazard_controller #(.FLUSH_CYCLES(3)) dut3 (.Clk(Clk), .Rst(Rst), .Hz(if3.slave));

  logic [4:0] obs2, obs3;
  assign obs2 = {if2.PCWrite, if2.IFIDWrite, if2.IDEXBubble, if2.FlushSignal, if2.PipeFreeze};
  assign obs3 = {if3.PCWrite, if3.IFIDWrite, if3.IDEXBubble, if3.FlushSignal, if3.PipeFreeze};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic stim_t mk(input logic [4:0] rs, rt, input logic uses, memRd,
                               input logic [4:0] idexRt, input logic br, busy,
                               input logic [4:0] e);
    stim_t s;
    s.rs = rs; s.rt = rt; s.uses = uses; s.memRd = memRd;
    s.idexRt = idexRt; s.br = br; s.busy = busy; s.exp = e;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    if2.IFID_Rs = s.rs; if2.IFID_Rt = s.rt; if2.IFID_UsesRt = s.uses;
    if2.IDEX_MemRead = s.memRd; if2.IDEX_Rt = s.idexRt;
    if2.BranchTaken = s.br; if2.DMemBusy = s.busy;
    if3.IFID_Rs = s.rs; if3.IFID_Rt = s.rt; if3.IFID_UsesRt = s.uses;
    if3.IDEX_MemRead = s.memRd; if3.IDEX_Rt = s.idexRt;
    if3.BranchTaken = s.br; if3.DMemBusy = s.busy;
  endtask

  task automatic doReset();
    Rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, IDLE));
    @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    apply(mk(5, 5, 1, 1, 5, 1, 1, IDLE));
    sbq.push_back(IDLE);
    #2;
    exp = sbq.pop_front();
    nChecks++;
    if (obs2 !== exp) begin nFail++; $display("FAIL reset_out2: got %b expected %b", obs2, exp); end
    nChecks++;
    if (obs3 !== exp) begin nFail++; $display("FAIL reset_out3: got %b expected %b", obs3, exp); end
    nChecks++;
    if (if2.StallCount !== 16'd0 || if2.FlushCount !== 16'd0) begin
      nFail++; $display("FAIL reset_counters: got %h/%h expected 0000/0000", if2.StallCount, if2.FlushCount);
    end
    @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t tbl[$];
    doReset();
    tbl = '{mk(5, 0, 0, 1, 5, 0, 0, LUS),
            mk(5, 0, 0, 0, 5, 0, 0, IDLE),
            mk(0, 0, 0, 1, 0, 0, 0, IDLE),
            mk(0, 0, 1, 1, 0, 0, 0, IDLE),
            mk(3, 9, 1, 1, 9, 0, 0, LUS),
            mk(3, 9, 0, 1, 9, 0, 0, IDLE),
            mk(4, 9, 1, 1, 7, 0, 0, IDLE)};
    foreach (tbl[i]) begin
      @(posedge Clk); #1 apply(tbl[i]); sbq.push_back(tbl[i].exp);
      @(negedge Clk); exp = sbq.pop_front(); nChecks++;
      if (obs2 !== exp) begin nFail++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs2, exp); end
    end
  endtask

  task automatic test_branch();
    stim_t tbl[$];
    doReset();
    tbl = '{mk(0, 0, 0, 0, 0, 1, 0, FL),
            mk(0, 0, 0, 0, 0, 1, 0, FL),
            mk(0, 0, 0, 0, 0, 0, 0, IDLE),
            mk(0, 0, 0, 0, 0, 0, 0, IDLE)};
    foreach (tbl[i]) begin
      @(posedge Clk); #1 apply(tbl[i]); sbq.push_back(tbl[i].exp);
      @(negedge Clk); exp = sbq.pop_front(); nChecks++;
      if (obs2 !== exp) begin nFail++; $display("FAIL branch[%0d]: got %b expected %b", i, obs2, exp); end
    end
    nChecks++;
    if (if2.FlushCount !== (STATS ? 16'd1 : 16'd0)) begin
      nFail++; $display("FAIL branch_flushcount: got %0d expected %0d", if2.FlushCount, STATS ? 1 : 0);
    end
  endtask

  task automatic test_freeze_branch();
    stim_t tbl[$];
    doReset();
    tbl = '{mk(0, 0, 0, 0, 0, 0, 1, FRZ),
            mk(0, 0, 0, 0, 0, 1, 1, FRZ),
            mk(0, 0, 0, 0, 0, 0, 1, FRZ),
            mk(0, 0, 0, 0, 0, 0, 1, FRZ),
            mk(0, 0, 0, 0, 0, 0, 0, FL),
            mk(0, 0, 0, 0, 0, 0, 0, FL),
            mk(0, 0, 0, 0, 0, 0, 0, IDLE)};
    foreach (tbl[i]) begin
      @(posedge Clk); #1 apply(tbl[i]); sbq.push_back(tbl[i].exp);
      @(negedge Clk); exp = sbq.pop_front(); nChecks++;
      if (obs2 !== exp) begin nFail++; $display("FAIL freeze_branch[%0d]: got %b expected %b", i, obs2, exp); end
    end
    nChecks++;
    if (if2.StallCount !== (STATS ? 16'd4 : 16'd0) || if2.FlushCount !== (STATS ? 16'd1 : 16'd0)) begin
      nFail++; $display("FAIL freeze_counters: got %0d/%0d expected %0d/%0d",
                        if2.StallCount, if2.FlushCount, STATS ? 4 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_priority();
    stim_t tbl[$];
    doReset();
    tbl = '{mk(6, 0, 0, 1, 6, 1, 1, FRZ),
            mk(6, 0, 0, 1, 6, 0, 0, FL),
            mk(6, 0, 0, 1, 6, 0, 0, FL),
            mk(6, 0, 0, 1, 6, 0, 0, LUS),
            mk(6, 0, 0, 1, 6, 1, 0, FL),
            mk(6, 0, 0, 1, 6, 1, 1, FRZ),
            mk(6, 0, 0, 0, 6, 0, 0, FL),
            mk(0, 0, 0, 0, 0, 0, 0, IDLE)};
    foreach (tbl[i]) begin
      @(posedge Clk); #1 apply(tbl[i]); sbq.push_back(tbl[i].exp);
      @(negedge Clk); exp = sbq.pop_front(); nChecks++;
      if (obs2 !== exp) begin nFail++; $display("FAIL priority[%0d]: got %b expected %b", i, obs2, exp); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t tbl[$];
    doReset();
    tbl = '{mk(7, 0, 0, 1, 7, 0, 1, FRZ),
            mk(7, 0, 0, 1, 7, 0, 0, LUS),
            mk(7, 0, 0, 1, 7, 0, 1, FRZ),
            mk(0, 0, 0, 0, 0, 0, 0, IDLE),
            mk(0, 0, 0, 0, 0, 1, 0, FL),
            mk(0, 0, 0, 0, 0, 0, 1, FRZ),
            mk(0, 0, 0, 0, 0, 0, 0, FL),
            mk(0, 0, 0, 0, 0, 0, 0, IDLE)};
    foreach (tbl[i]) begin
      @(posedge Clk); #1 apply(tbl[i]); sbq.push_back(tbl[i].exp);
      @(negedge Clk); exp = sbq.pop_front(); nChecks++;
      if (obs2 !== exp) begin nFail++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs2, exp); end
    end
  endtask

  task automatic test_reset_mid_flush();
    stim_t pre[$];
    stim_t post[$];
    doReset();
    pre  = '{mk(0, 0, 0, 0, 0, 1, 0, FL), mk(0, 0, 0, 0, 0, 0, 0, FL)};
    post = '{mk(0, 0, 0, 0, 0, 0, 0, IDLE), mk(0, 0, 0, 0, 0, 0, 0, IDLE),
             mk(0, 0, 0, 0, 0, 0, 0, IDLE)};
    foreach (pre[i]) begin
      @(posedge Clk); #1 apply(pre[i]); sbq.push_back(pre[i].exp);
      @(negedge Clk); exp = sbq.pop_front(); nChecks++;
      if (obs3 !== exp) begin nFail++; $display("FAIL flush3[%0d]: got %b expected %b", i, obs3, exp); end
    end
    #1 Rst = 1'b1;
    sbq.push_back(IDLE);
    #1 exp = sbq.pop_front(); nChecks++;
    if (obs3 !== exp) begin nFail++; $display("FAIL async_reset_out: got %b expected %b", obs3, exp); end
    @(posedge Clk);
    #1 Rst = 1'b0;
    foreach (post[i]) begin
      @(posedge Clk); #1 apply(post[i]); sbq.push_back(post[i].exp);
      @(negedge Clk); exp = sbq.pop_front(); nChecks++;
      if (obs3 !== exp) begin nFail++; $display("FAIL post_reset[%0d]: got %b expected %b", i, obs3, exp); end
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_saturation();
    doReset();
    apply(mk(0, 0, 0, 0, 0, 0, 1, FRZ));
    repeat (65534) @(posedge Clk);
    @(negedge Clk);
    nChecks++;
    if (if2.StallCount !== 16'hFFFE) begin
      nFail++; $display("FAIL stall_near_sat: got %h expected fffe", if2.StallCount);
    end
    repeat (70000 - 65534) @(posedge Clk);
    @(negedge Clk);
    nChecks++;
    if (if2.StallCount !== 16'hFFFF) begin
      nFail++; $display("FAIL stall_saturated: got %h expected ffff", if2.StallCount);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, IDLE));
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze_branch();
    test_priority();
    test_back_to_back();
    test_reset_mid_flush();
`ifdef HAZARD_STATS_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
